dcache_ctrl: RTL and testbench
==============================

# dcache_ctrl

Controller for the data-side cache. It sequences a 16-line, one-word-per-line, direct-mapped, write-back cache between the CPU load/store port and a multi-cycle backing data memory. It owns the tag, valid and dirty state, stalls the pipeline on misses, and runs victim write-back and line fill over a req/ready handshake. It also keeps hit and miss counters for performance checks.

## Interface
- LINES, 16: number of cache lines; power of two; index = address[log2(LINES)-1:0].
- MEM_WORDS, 1024: cacheable word-address range [0, MEM_WORDS).
- clk  in  1  system clock; all state changes on the rising edge.
- resetn  in  1  synchronous, active-low reset.
- address  in  32  CPU word address; held stable while stall=1.
- writeData  in  32  store data.
- memRead  in  1  load request.
- memWrite  in  1  store request; wins if memRead is also high.
- readData  out  32  load data, combinational; valid when memRead=1 and stall=0.
- stall  out  1  combinational; freezes the CPU.
- memReq  out  1  backing-memory request, held until memReady.
- memWe  out  1  1 = write-back, 0 = fill read.
- memAddr  out  32  backing-memory word address.
- memWData  out  32  victim data.
- memRData  in  32  fill data; valid with memReady.
- memReady  in  1  transaction completes at the rising edge where memReq=1 and memReady=1.
- hitCount  out  16  saturating hit counter.
- missCount  out  16  saturating miss counter.

## Operation
- Line fields: idx = address mod LINES, tag = address / LINES; hit = valid[idx] and tag match.
- Uncached access (address >= MEM_WORDS): readData=0, stores ignored, stall=0, counters unchanged.
- States: IDLE, WB, FILL.
- IDLE, no request: stall=0, memReq=0.
- IDLE, read hit: readData=line data, stall=0.
- IDLE, write hit: line is written and marked dirty at the edge, stall=0.
- IDLE, miss: stall=1 in the same cycle; missCount increments at the edge.
  - If the victim is valid and dirty, go to WB.
  - Otherwise a read miss goes to FILL.
  - Otherwise a write miss installs writeData with valid=1, dirty=1 and the new tag, then stays in IDLE.
- WB: memReq=1, memWe=1, memAddr=victim tag*LINES+idx, memWData=victim data, stall=1.
  - On memReady: read miss goes to FILL; write miss installs writeData as in IDLE and returns to IDLE.
- FILL: memReq=1, memWe=0, memAddr=address, stall=1.
  - On memReady: the line gets memRData, valid=1, dirty=0 and the new tag; return to IDLE.
- Retry: back in IDLE, the still-held request hits and completes. This retried hit is not counted in hitCount; a one-bit retry flag is set at fill/install and cleared by the completing access.
- hitCount increments once per completed cached access that hit on first lookup.
- Both counters saturate at 0xFFFF.
- Request dropped while in WB/FILL: the memory transaction still completes and the line is updated; the state returns to IDLE.
- Address change while stall=1 is a protocol violation; behaviour is undefined and flagged by an assertion.

## Timing
- Reset (resetn=0 at an edge):
  - all valid and dirty bits = 0; state = IDLE.
  - memReq=0, memWe=0, memAddr=0, memWData=0, hitCount=0, missCount=0.
  - stall and readData are then purely combinational from the inputs.
- Reset mid-WB or mid-FILL: the transaction is abandoned, memReq=0 after the edge, dirty data is lost.
- Hit latency: 0 stall cycles.
- Clean read miss: stall for 1 + F cycles, where F = cycles spent in FILL (F >= 1); data is returned in the retry cycle.
- Dirty read miss: stall for 1 + W + F cycles, where W = cycles spent in WB.
- Clean write miss: 1 stall cycle. Dirty write miss: 1 + W stall cycles.
- memReq, memWe, memAddr and memWData are registered/state-decoded and stable for the whole transaction.
- memReady while memReq=0 is ignored.

## Test plan
- Reset, then read address 5 (memory holds 0xAAAA0005, ready after 2 cycles) -> stall for 3 cycles, memReq/memWe=0/memAddr=5, then readData=0xAAAA0005; missCount=1, hitCount=0.
- Read address 5 again -> stall=0, readData=0xAAAA0005, hitCount=1.
- Write 0x1234 to address 21 (same index as 5), then read address 5 -> the write gives 1 stall cycle; the read gives a WB (memWe=1, memAddr=21, memWData=0x1234) then a FILL with memAddr=5.
- memRead=1 and memWrite=1 together at address 7 with writeData=0xBEEF -> treated as a write; line 7 dirty; a later read of address 7 hits with 0xBEEF.
- Access address 2000 (memRead or memWrite) -> readData=0, stall=0, no memReq, counters unchanged.
- resetn=0 during WB -> memReq=0 next cycle; all lines invalid; the following read of the same address misses and does not write back.

Source files
------------

// File: rtl/dcache_ctrl_if.sv
// dcache_ctrl_if: bundle of the CPU load/store port and the backing-memory
// req/ready port of the data-cache controller.
//   CPU side   : address, writeData, memRead, memWrite -> readData, stall
//   Memory side: memReq, memWe, memAddr, memWData -> memRData, memReady
//   Statistics : hitCount, missCount
// Modport slave is the controller's view; modport master is the view of the
// surrounding CPU pipeline plus backing memory.
interface dcache_ctrl_if;
    logic [31:0] address;
    logic [31:0] writeData;
    logic        memRead;
    logic        memWrite;
    logic [31:0] readData;
    logic        stall;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memWData;
    logic [31:0] memRData;
    logic        memReady;
    logic [15:0] hitCount;
    logic [15:0] missCount;

    modport slave (
        input  address, writeData, memRead, memWrite, memRData, memReady,
        output readData, stall, memReq, memWe, memAddr, memWData, hitCount, missCount
    );

    modport master (
        output address, writeData, memRead, memWrite, memRData, memReady,
        input  readData, stall, memReq, memWe, memAddr, memWData, hitCount, missCount
    );
endinterface

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, one-word-per-line, write-back data cache
// controller. Owns tag/valid/dirty/data state, stalls the CPU on misses and
// runs victim write-back (WB) and line fill (FILL) over a req/ready handshake.
// Ports:
//   clk    - rising-edge clock
//   resetn - synchronous active-low reset
//   bus    - dcache_ctrl_if.slave (CPU port, memory port, hit/miss counters)
// readData and stall are combinational; memory-side outputs are registered.

// Protocol checker: a stalled request must keep its address until it completes.
module dcache_ctrl_chk (
    input logic        clk,
    input logic        resetn,
    input logic        stall,
    input logic        req,
    input logic [31:0] address
);
    property p_addr_stable;
        @(posedge clk) disable iff (!resetn)
            ($past(stall) && $past(resetn) && req) |-> (address == $past(address));
    endproperty

    a_addr_stable: assert property (p_addr_stable)
        else $error("dcache_ctrl: address changed while stalled");
endmodule

module dcache_ctrl #(
    parameter int LINES     = 16,
    parameter int MEM_WORDS = 1024
) (
    input logic          clk,
    input logic          resetn,
    dcache_ctrl_if.slave bus
);
    localparam int          IDX_W     = $clog2(LINES);
    localparam int          TAG_W     = 32 - IDX_W;
    localparam logic [31:0] MEM_LIMIT = 32'(MEM_WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WB   = 2'd1,
        S_FILL = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [LINES-1:0] valid_q, valid_d;
    logic [LINES-1:0] dirty_q, dirty_d;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [TAG_W-1:0] tag_d  [LINES];
    logic [31:0]      data_q [LINES];
    logic [31:0]      data_d [LINES];
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic [15:0]      hit_cnt_q, hit_cnt_d;
    logic [15:0]      miss_cnt_q, miss_cnt_d;
    logic             retry_q, retry_d;      // next lookup is the retry of a miss
    logic             op_write_q, op_write_d; // the pending miss is a store

    logic [IDX_W-1:0] idx_s;
    logic [TAG_W-1:0] tag_s;
    logic [IDX_W-1:0] fill_idx_s;
    logic [TAG_W-1:0] fill_tag_s;
    logic             cached_s;
    logic             req_s;
    logic             hit_s;
    logic             victim_dirty_s;
    logic             stall_s;
    logic [31:0]      rdata_s;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign idx_s          = bus.address[IDX_W-1:0];
    assign tag_s          = bus.address[31:IDX_W];
    // The fill target is taken from the registered request address.
    assign fill_idx_s     = mem_addr_q[IDX_W-1:0];
    assign fill_tag_s     = mem_addr_q[31:IDX_W];
    assign cached_s       = (bus.address < MEM_LIMIT);
    assign req_s          = bus.memRead | bus.memWrite;
    assign hit_s          = valid_q[idx_s] && (tag_q[idx_s] == tag_s);
    assign victim_dirty_s = valid_q[idx_s] && dirty_q[idx_s];

    // Next-state, line update, counters and combinational CPU outputs
    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        tag_d       = tag_q;
        data_d      = data_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        retry_d     = retry_q;
        op_write_d  = op_write_q;
        stall_s     = 1'b0;
        rdata_s     = 32'd0;
        case (state_q)
            S_IDLE: begin
                if (cached_s && req_s) begin
                    retry_d = 1'b0;
                    if (hit_s) begin
                        if (retry_q) begin
                            hit_cnt_d = hit_cnt_q;
                        end else begin
                            hit_cnt_d = sat_inc(hit_cnt_q);
                        end
                        if (bus.memWrite) begin
                            data_d[idx_s]  = bus.writeData;
                            dirty_d[idx_s] = 1'b1;
                        end else begin
                            rdata_s = data_q[idx_s];
                        end
                    end else begin
                        stall_s    = 1'b1;
                        miss_cnt_d = sat_inc(miss_cnt_q);
                        op_write_d = bus.memWrite;
                        if (victim_dirty_s) begin
                            state_d     = S_WB;
                            mem_req_d   = 1'b1;
                            mem_we_d    = 1'b1;
                            mem_addr_d  = {tag_q[idx_s], idx_s};
                            mem_wdata_d = data_q[idx_s];
                        end else if (!bus.memWrite) begin
                            state_d    = S_FILL;
                            mem_req_d  = 1'b1;
                            mem_we_d   = 1'b0;
                            mem_addr_d = bus.address;
                        end else begin
                            // Clean write miss: allocate directly, no fill needed.
                            valid_d[idx_s] = 1'b1;
                            dirty_d[idx_s] = 1'b1;
                            tag_d[idx_s]   = tag_s;
                            data_d[idx_s]  = bus.writeData;
                            retry_d        = 1'b1;
                        end
                    end
                end else begin
                    retry_d = retry_q;
                end
            end
            S_WB: begin
                stall_s = 1'b1;
                if (bus.memReady) begin
                    // Victim is now in memory; line stays valid but clean.
                    dirty_d[fill_idx_s] = 1'b0;
                    if (req_s && op_write_q) begin
                        valid_d[idx_s] = 1'b1;
                        dirty_d[idx_s] = 1'b1;
                        tag_d[idx_s]   = tag_s;
                        data_d[idx_s]  = bus.writeData;
                        retry_d        = 1'b1;
                        state_d        = S_IDLE;
                        mem_req_d      = 1'b0;
                        mem_we_d       = 1'b0;
                    end else if (req_s) begin
                        state_d    = S_FILL;
                        mem_we_d   = 1'b0;
                        mem_addr_d = bus.address;
                    end else begin
                        state_d   = S_IDLE;
                        mem_req_d = 1'b0;
                        mem_we_d  = 1'b0;
                    end
                end else begin
                    state_d = S_WB;
                end
            end
            S_FILL: begin
                stall_s = 1'b1;
                if (bus.memReady) begin
                    valid_d[fill_idx_s] = 1'b1;
                    dirty_d[fill_idx_s] = 1'b0;
                    tag_d[fill_idx_s]   = fill_tag_s;
                    data_d[fill_idx_s]  = bus.memRData;
                    retry_d             = req_s;
                    state_d             = S_IDLE;
                    mem_req_d           = 1'b0;
                end else begin
                    state_d = S_FILL;
                end
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    // State, line storage and memory-port registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            valid_q     <= {LINES{1'b0}};
            dirty_q     <= {LINES{1'b0}};
            for (int i = 0; i < LINES; i++) begin
                tag_q[i]  <= {TAG_W{1'b0}};
                data_q[i] <= 32'd0;
            end
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            hit_cnt_q   <= 16'd0;
            miss_cnt_q  <= 16'd0;
            retry_q     <= 1'b0;
            op_write_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            tag_q       <= tag_d;
            data_q      <= data_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            retry_q     <= retry_d;
            op_write_q  <= op_write_d;
        end
    end

    assign bus.readData  = rdata_s;
    assign bus.stall     = stall_s;
    assign bus.memReq    = mem_req_q;
    assign bus.memWe     = mem_we_q;
    assign bus.memAddr   = mem_addr_q;
    assign bus.memWData  = mem_wdata_q;
    assign bus.hitCount  = hit_cnt_q;
    assign bus.missCount = miss_cnt_q;

    dcache_ctrl_chk u_chk (
        .clk     (clk),
        .resetn  (resetn),
        .stall   (stall_s),
        .req     (req_s),
        .address (bus.address)
    );
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: scoreboard bench for dcache_ctrl. A driver issues CPU
// accesses and pushes the expected memory transactions and load data,
// computed by a line/memory array model, into queues; a monitor pops and
// compares them whenever the DUT completes a load or a memory handshake.
// A responder process plays the backing memory with random latency.
module tb_dcache_ctrl;
    localparam int LINES     = 16;
    localparam int MEM_WORDS = 1024;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_txn_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    dcache_ctrl_if bus ();

    dcache_ctrl #(.LINES(LINES), .MEM_WORDS(MEM_WORDS)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int vectors = 0;
    int miscompares = 0;
    int busy_cycles = 0;
    int fixed_delay = -1;

    mem_txn_t    mem_exp[$];
    logic [31:0] rd_exp[$];

    // reference model state
    bit          ref_v[LINES];
    bit          ref_d[LINES];
    int          ref_t[LINES];
    logic [31:0] ref_data[LINES];
    logic [31:0] ref_mem[MEM_WORDS];
    logic [31:0] bmem[MEM_WORDS];
    int          ref_hits;
    int          ref_misses;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < LINES; i++) begin
            ref_v[i] = 1'b0;
            ref_d[i] = 1'b0;
        end
        ref_hits   = 0;
        ref_misses = 0;
    endtask

    task automatic model_access(input bit rd, input bit wr, input logic [31:0] a,
                                input logic [31:0] wd, output bit miss);
        int idx;
        int tg;
        mem_txn_t t;
        miss = 1'b0;
        if (a >= MEM_WORDS) begin
            if (rd && !wr) rd_exp.push_back(32'd0);
            return;
        end
        idx = int'(a % LINES);
        tg  = int'(a / LINES);
        if (ref_v[idx] && ref_t[idx] == tg) begin
            ref_hits = (ref_hits >= 65535) ? 65535 : ref_hits + 1;
            if (wr) begin
                ref_data[idx] = wd;
                ref_d[idx]    = 1'b1;
            end else begin
                rd_exp.push_back(ref_data[idx]);
            end
        end else begin
            miss       = 1'b1;
            ref_misses = (ref_misses >= 65535) ? 65535 : ref_misses + 1;
            if (ref_v[idx] && ref_d[idx]) begin
                t.we    = 1'b1;
                t.addr  = 32'(ref_t[idx] * LINES + idx);
                t.wdata = ref_data[idx];
                mem_exp.push_back(t);
                ref_mem[t.addr[9:0]] = ref_data[idx];
            end
            if (wr) begin
                ref_data[idx] = wd;
                ref_d[idx]    = 1'b1;
            end else begin
                t.we    = 1'b0;
                t.addr  = a;
                t.wdata = 32'd0;
                mem_exp.push_back(t);
                ref_data[idx] = ref_mem[a[9:0]];
                ref_d[idx]    = 1'b0;
                rd_exp.push_back(ref_data[idx]);
            end
            ref_v[idx] = 1'b1;
            ref_t[idx] = tg;
        end
    endtask

    // one CPU access held until stall drops; returns the stall cycle count
    task automatic do_access(input bit rd, input bit wr, input logic [31:0] a,
                             input logic [31:0] wd, output int stalls);
        bit miss;
        int busy0;
        int exp_stalls;
        model_access(rd, wr, a, wd, miss);
        @(posedge clk); #1;
        bus.address   = a;
        bus.writeData = wd;
        bus.memRead   = rd;
        bus.memWrite  = wr;
        busy0  = busy_cycles;
        stalls = 0;
        @(negedge clk);
        while (bus.stall && stalls < 100) begin
            stalls++;
            @(negedge clk);
        end
        if (bus.stall) check("stall_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        bus.memRead  = 1'b0;
        bus.memWrite = 1'b0;
        exp_stalls = miss ? 1 + (busy_cycles - busy0) : 0;
        check("stall_cycles", 32'(stalls), 32'(exp_stalls));
        check("hitCount", {16'd0, bus.hitCount}, 32'(ref_hits));
        check("missCount", {16'd0, bus.missCount}, 32'(ref_misses));
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        model_reset();
    endtask

    // backing memory: random ready latency, writes applied at the handshake
    initial begin : responder
        int delay;
        bit hs;
        logic hs_we;
        logic [31:0] hs_addr;
        logic [31:0] hs_wdata;
        delay = -1;
        bus.memReady = 1'b0;
        bus.memRData = 32'd0;
        forever begin
            @(negedge clk);
            hs       = resetn && bus.memReq && bus.memReady;
            hs_we    = bus.memWe;
            hs_addr  = bus.memAddr;
            hs_wdata = bus.memWData;
            if (bus.memReq) busy_cycles++;
            @(posedge clk); #2;
            if (hs && hs_we) bmem[hs_addr[9:0]] = hs_wdata;
            if (hs || !bus.memReq) begin
                bus.memReady = 1'b0;
                delay = -1;
            end
            if (bus.memReq && !bus.memReady) begin
                if (delay < 0) delay = (fixed_delay >= 0) ? fixed_delay : $urandom_range(0, 2);
                if (delay == 0) begin
                    bus.memReady = 1'b1;
                    bus.memRData = bus.memWe ? 32'hDEADBEEF : bmem[bus.memAddr[9:0]];
                end else begin
                    delay--;
                end
            end
        end
    end

    // monitor: compare memory handshakes and completed loads against the queues
    initial begin : monitor
        mem_txn_t e;
        logic [31:0] r;
        forever begin
            @(negedge clk);
            if (resetn && bus.memReq && bus.memReady) begin
                if (mem_exp.size() == 0) begin
                    check("mem_txn_unexpected", bus.memAddr, 32'hFFFFFFFF);
                end else begin
                    e = mem_exp.pop_front();
                    check("memWe", {31'd0, bus.memWe}, {31'd0, e.we});
                    check("memAddr", bus.memAddr, e.addr);
                    if (e.we) check("memWData", bus.memWData, e.wdata);
                end
            end
            if (resetn && bus.memRead && !bus.memWrite && !bus.stall) begin
                if (rd_exp.size() == 0) begin
                    check("read_unexpected", bus.readData, 32'hFFFFFFFF);
                end else begin
                    r = rd_exp.pop_front();
                    check("readData", bus.readData, r);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "tb_dcache_ctrl timeout");
    end

    initial begin : driver
        int st;
        int n;
        bus.address   = 32'd0;
        bus.writeData = 32'd0;
        bus.memRead   = 1'b0;
        bus.memWrite  = 1'b0;
        for (int i = 0; i < MEM_WORDS; i++) begin
            bmem[i]    = 32'hAAAA0000 | 32'(i);
            ref_mem[i] = 32'hAAAA0000 | 32'(i);
        end
        apply_reset();
        @(negedge clk);
        check("rst_memReq", {31'd0, bus.memReq}, 32'd0);
        check("rst_memWe", {31'd0, bus.memWe}, 32'd0);
        check("rst_memAddr", bus.memAddr, 32'd0);
        check("rst_memWData", bus.memWData, 32'd0);
        check("rst_hitCount", {16'd0, bus.hitCount}, 32'd0);
        check("rst_missCount", {16'd0, bus.missCount}, 32'd0);
        check("rst_stall", {31'd0, bus.stall}, 32'd0);

        // clean read miss with fill ready in the second FILL cycle
        fixed_delay = 1;
        do_access(1'b1, 1'b0, 32'd5, 32'd0, st);
        check("clean_miss_stalls", 32'(st), 32'd3);
        fixed_delay = -1;
        do_access(1'b1, 1'b0, 32'd5, 32'd0, st);

        // conflicting store, then a dirty-victim read miss
        do_access(1'b0, 1'b1, 32'd21, 32'h00001234, st);
        check("clean_wmiss_stalls", 32'(st), 32'd1);
        do_access(1'b1, 1'b0, 32'd5, 32'd0, st);

        // simultaneous read and write is a write
        do_access(1'b1, 1'b1, 32'd7, 32'h0000BEEF, st);
        do_access(1'b1, 1'b0, 32'd7, 32'd0, st);

        // uncached accesses
        do_access(1'b1, 1'b0, 32'd2000, 32'd0, st);
        do_access(1'b0, 1'b1, 32'd2000, 32'h11111111, st);
        do_access(1'b1, 1'b1, 32'd2000, 32'h22222222, st);
        check("uncached_memReq", {31'd0, bus.memReq}, 32'd0);

        // reset while a write-back is pending
        do_access(1'b0, 1'b1, 32'd5, 32'h00005555, st);
        fixed_delay = 50;
        @(posedge clk); #1;
        bus.address = 32'd21;
        bus.memRead = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.memReq && n < 10) begin
            n++;
            @(negedge clk);
        end
        check("wb_memWe", {31'd0, bus.memWe}, 32'd1);
        check("wb_memAddr", bus.memAddr, 32'd5);
        check("wb_memWData", bus.memWData, 32'h00005555);
        @(posedge clk); #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        bus.memRead = 1'b0;
        check("rst_wb_memReq", {31'd0, bus.memReq}, 32'd0);
        fixed_delay = -1;
        model_reset();
        do_access(1'b1, 1'b0, 32'd21, 32'd0, st);

        // randomized traffic
        for (int k = 0; k < 300; k++) begin
            logic [31:0] a;
            bit rd;
            bit wr;
            if ($urandom_range(0, 9) == 0) a = 32'(MEM_WORDS) + 32'($urandom_range(0, 3000));
            else a = 32'($urandom_range(0, 63));
            case ($urandom_range(0, 2))
                0: begin rd = 1'b1; wr = 1'b0; end
                1: begin rd = 1'b0; wr = 1'b1; end
                default: begin rd = 1'b1; wr = 1'b1; end
            endcase
            do_access(rd, wr, a, $urandom, st);
        end

        repeat (3) @(posedge clk);
        check("mem_exp_drained", 32'(mem_exp.size()), 32'd0);
        check("rd_exp_drained", 32'(rd_exp.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
